// File: rtl/alu_seg_pkg.sv
// Shared definitions for the switch-driven ALU with seven-segment readout.
// Holds the opcode encodings, the active-low hex font and the blank pattern.
package alu_seg_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_LT  = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low font, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex2seg(input logic [3:0] i_nib);
        logic [6:0] w_seg;
        unique case (i_nib)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
        endcase
        return w_seg;
    endfunction

endpackage

// File: rtl/alu_seg_if.sv
// Board-side bundle: switch inputs (ins, op) and display pins (seg, ans).
// master = board wrapper / bench, slave = alu_seg_top.
interface alu_seg_if;

    logic [7:0] ins;
    logic [2:0] op;
    logic [6:0] seg;
    logic [7:0] ans;

    modport master (
        output ins,
        output op,
        input  seg,
        input  ans
    );

    modport slave (
        input  ins,
        input  op,
        output seg,
        output ans
    );

endinterface

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner.
// Ports: clk, rst (async high), i_nib[8] nibbles, i_blank[8] flags -> o_seg, o_ans (active-low).
module seg7_scan
    import alu_seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0][3:0] i_nib,
    input  logic [7:0]      i_blank,
    output logic [6:0]      o_seg,
    output logic [7:0]      o_ans
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Anodes come straight from the index register; segments follow
    // the live nibble so both switch on the same edge.
    always_comb begin
        o_ans = ~(8'b1 << r_idx);
        o_seg = i_blank[r_idx] ? SEG_BLANK : hex2seg(i_nib[r_idx]);
    end

endmodule

// File: rtl/alu_seg_top.sv
// Registered 4-bit ALU whose operands, opcode and result drive an 8-digit display.
// Ports: clk, rst (async high), bus (slave: ins, op in; seg, ans out).
module alu_seg_top
    import alu_seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic         clk,
    input  logic         rst,
    alu_seg_if.slave     bus
);

    logic [3:0]      w_a;
    logic [3:0]      w_b;
    logic [7:0]      w_ax;
    logic [7:0]      w_bx;
    logic [7:0]      w_alu;
    logic [7:0]      r_result;
    logic [7:0][3:0] w_nib;
    logic [7:0]      w_blank;

    assign w_a  = bus.ins[7:4];
    assign w_b  = bus.ins[3:0];
    assign w_ax = {4'h0, w_a};
    assign w_bx = {4'h0, w_b};

    always_comb begin
        w_alu = 8'h00;
        unique case (bus.op)
            OP_ADD: w_alu = w_ax + w_bx;
            OP_SUB: w_alu = w_ax - w_bx;
            OP_AND: w_alu = w_ax & w_bx;
            OP_OR:  w_alu = w_ax | w_bx;
            OP_XOR: w_alu = w_ax ^ w_bx;
            OP_NOT: w_alu = {4'h0, ~w_a};
            OP_LT:  w_alu = {7'd0, (w_a < w_b)};
            OP_MUL: w_alu = w_ax * w_bx;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 8'h00;
        end else begin
            r_result <= w_alu;
        end
    end

    // Digit 7 is leftmost; digits 5, 3 and 2 are unused and blanked.
    always_comb begin
        w_nib[7] = w_a;
        w_nib[6] = w_b;
        w_nib[5] = 4'h0;
        w_nib[4] = {1'b0, bus.op};
        w_nib[3] = 4'h0;
        w_nib[2] = 4'h0;
        w_nib[1] = r_result[7:4];
        w_nib[0] = r_result[3:0];
    end

    assign w_blank = 8'b0010_1100;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .i_nib   (w_nib),
        .i_blank (w_blank),
        .o_seg   (bus.seg),
        .o_ans   (bus.ans)
    );

endmodule

// File: tb/tb_alu_seg_top.sv
// Directed self-checking bench for alu_seg_top with a fast scan divider.
// Drives switch vectors and checks the result register and display pins.
module tb_alu_seg_top;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_seg_if bus();

    alu_seg_top #(
        .SCAN_DIV (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (sampling on falling edges) until digit d is selected.
    task automatic wait_digit(input int d, output bit ok);
        logic [7:0] want;
        want = ~(8'b1 << d);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ans === want) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL digit_timeout d=%0d ans=%h", d, bus.ans);
        end
    endtask

    task automatic check_digit(input string nm, input int d,
                               input logic [6:0] exp);
        bit ok;
        wait_digit(d, ok);
        if (ok) begin
            n_checks++;
            if (bus.seg !== exp) begin
                n_fail++;
                $display("FAIL %s seg=%h want=%h", nm, bus.seg, exp);
            end
        end
    endtask

    task automatic apply(input logic [7:0] ins, input logic [2:0] op,
                         input logic [7:0] exp, input string nm);
        @(negedge clk);
        bus.ins = ins;
        bus.op  = op;
        @(posedge clk);
        #1;
        n_checks++;
        if (dut.r_result !== exp) begin
            n_fail++;
            $display("FAIL %s result=%h want=%h", nm, dut.r_result, exp);
        end
    endtask

    task automatic test_reset();
        logic [7:0] want;
        #1;
        n_checks++;
        if (bus.ans !== 8'hFE) begin
            n_fail++;
            $display("FAIL rst_ans ans=%h want=fe", bus.ans);
        end
        n_checks++;
        if (bus.seg !== 7'h40) begin
            n_fail++;
            $display("FAIL rst_seg seg=%h want=40", bus.seg);
        end
        n_checks++;
        if (dut.r_result !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_result result=%h want=00", dut.r_result);
        end
        #9;
        rst = 1'b0;
        #10;
        n_checks++;
        if (bus.ans !== 8'hFE) begin
            n_fail++;
            $display("FAIL walk0 ans=%h want=fe", bus.ans);
        end
        for (int k = 1; k <= 8; k++) begin
            #20;
            want = ~(8'b1 << (k % 8));
            n_checks++;
            if (bus.ans !== want) begin
                n_fail++;
                $display("FAIL walk%0d ans=%h want=%h", k, bus.ans, want);
            end
        end
    endtask

    task automatic test_add_display();
        apply(8'h01, 3'b000, 8'h01, "add_01");
        check_digit("d0_add", 0, 7'h79);
        check_digit("d7_A", 7, 7'h40);
        check_digit("d6_B", 6, 7'h79);
        check_digit("d4_op0", 4, 7'h40);
        check_digit("d5_blank", 5, 7'h7F);
        check_digit("d3_blank", 3, 7'h7F);
    endtask

    task automatic test_sub_display();
        apply(8'h02, 3'b001, 8'hFE, "sub_0_2");
        check_digit("d1_F", 1, 7'h0E);
        check_digit("d0_E", 0, 7'h06);
    endtask

    task automatic test_logic_ops();
        apply(8'h02, 3'b010, 8'h00, "and");
        apply(8'h02, 3'b011, 8'h02, "or");
        apply(8'h02, 3'b100, 8'h02, "xor");
        apply(8'h02, 3'b101, 8'h0F, "not_a");
    endtask

    task automatic test_arith_edges();
        apply(8'h35, 3'b110, 8'h01, "lt_3_5");
        apply(8'h53, 3'b110, 8'h00, "lt_5_3");
        apply(8'h35, 3'b111, 8'h0F, "mul_3_5");
        apply(8'hFF, 3'b000, 8'h1E, "add_f_f");
        apply(8'hFF, 3'b111, 8'hE1, "mul_f_f");
        check_digit("d1_E", 1, 7'h06);
        check_digit("d0_1", 0, 7'h79);
        check_digit("d4_op7", 4, 7'h78);
        check_digit("d7_F", 7, 7'h0E);
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply(8'hFF, 3'b000, 8'h1E, "pre_rst");
        wait_digit(5, ok);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.ans !== 8'hFE) begin
            n_fail++;
            $display("FAIL mid_rst_ans ans=%h want=fe", bus.ans);
        end
        n_checks++;
        if (dut.r_result !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_rst_result result=%h want=00",
                     dut.r_result);
        end
        n_checks++;
        if (bus.seg !== 7'h40) begin
            n_fail++;
            $display("FAIL mid_rst_seg seg=%h want=40", bus.seg);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.ans !== 8'hFE) begin
            n_fail++;
            $display("FAIL restart0 ans=%h want=fe", bus.ans);
        end
        @(negedge clk);
        n_checks++;
        if (bus.ans !== 8'hFD) begin
            n_fail++;
            $display("FAIL restart1 ans=%h want=fd", bus.ans);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.ins  = 8'h00;
        bus.op   = 3'b000;
        test_reset();
        test_add_display();
        test_sub_display();
        test_logic_ops();
        test_arith_edges();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
